request_queue: RTL

//  Pending-request buffer directly downstream of the trace parser. Captures each strobed
//  op (opcode + address) into a DEPTH-entry circular FIFO and presents the oldest entry
//  to the DRAM command scheduler over a valid/ready handshake. Reports fullness,

---
 rtl/request_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/request_queue.sv
// request_queue: DEPTH-entry circular FIFO between trace parser and DRAM scheduler.
// Optional per-entry age tracking is enabled by defining REQ_QUEUE_AGE_EN.

package global_defs;
   localparam int ADDRESS_WIDTH = 33;
   typedef enum logic [1:0] {
      NOP     = 2'd0,
      READ    = 2'd1,
      WRITE   = 2'd2,
      REFRESH = 2'd3
   } parsed_op_t;
endpackage

module request_queue
   import global_defs::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = ADDRESS_WIDTH,
   parameter int AGE_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  parsed_op_t                 in_opcode,
   input  logic [AW-1:0]              in_address,
   output logic                       in_ready,
   output logic                       out_valid,
   output parsed_op_t                 out_opcode,
   output logic [AW-1:0]              out_address,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [AGE_W-1:0]           head_age
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          ovf_q;
   logic          enq;
   logic          deq;

   parsed_op_t    op_mem   [DEPTH];
   logic [AW-1:0] addr_mem [DEPTH];

   // Fullness comes from the occupancy counter, so pointers may wrap freely.
   assign full      = (cnt == CW'(DEPTH));
   assign empty     = (cnt == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign enq       = in_valid && in_ready;
   assign deq       = out_valid && out_ready;
   assign count     = cnt;
   assign overflow  = ovf_q;

   // Head is forced to NOP/0 when empty so the scheduler never sees stale data.
   assign out_opcode  = empty ? NOP : op_mem[rd_ptr];
   assign out_address = empty ? '0  : addr_mem[rd_ptr];

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({enq, deq})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         if (in_valid && full) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Entry storage; deliberately not reset, occupancy alone says what is live.
   always_ff @(posedge clk) begin
      if (enq) begin
         op_mem[wr_ptr]   <= in_opcode;
         addr_mem[wr_ptr] <= in_address;
      end
   end

`ifdef REQ_QUEUE_AGE_EN
   logic [AGE_W-1:0] age_mem [DEPTH];

   // Ages restart on enqueue and saturate; free slots may count, they are
   // overwritten before they can ever reach the head.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (enq && (wr_ptr == PW'(i))) begin
            age_mem[i] <= '0;
         end else if (age_mem[i] != '1) begin
            age_mem[i] <= age_mem[i] + AGE_W'(1);
         end
      end
   end

   assign head_age = empty ? '0 : age_mem[rd_ptr];
`else
   assign head_age = '0;
`endif

`ifndef SYNTHESIS
   // Unknown strobes or opcodes must never be captured.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!$isunknown(in_valid));
         if (in_valid === 1'b1) begin
            assert (!$isunknown(in_opcode));
         end
      end
   end
`endif

endmodule
